// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results (priority) with a queued load/DMA stream onto the
// register-file write port. Optional macro WB_BYPASS_EN adds combinational forwarding outputs.
module wb_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dir,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_dir,
    input  logic [31:0] ld_data,
    output logic        REG_WR,
    output logic [4:0]  DIR_WR,
    output logic [31:0] DI,
    output logic [31:0] busy_mask,
`ifdef WB_BYPASS_EN
    output logic        byp_valid,
    output logic [4:0]  byp_dir,
    output logic [31:0] byp_data,
`endif
    output logic        stall_req
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [4:0]       dir_q  [DEPTH];
    logic [4:0]       dir_d  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       dir_wr_q, dir_wr_d;
    logic [31:0]      di_q, di_d;
    logic [31:0]      busy_q, busy_d;

    logic alu_eff;
    logic push;
    logic pop;

    assign alu_eff  = alu_valid && (alu_dir != 5'd0);
    assign ld_ready = (count_q < CW'(DEPTH));
    assign push     = ld_valid && ld_ready;
    assign pop      = !alu_eff && (count_q != '0);

    // Queue next state, cancellation and busy mask
    always_comb begin
        dir_d    = dir_q;
        data_d   = data_q;
        kill_d   = kill_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        busy_d   = '0;

        if (alu_eff) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i] && (dir_q[i] == alu_dir)) kill_d[i] = 1'b1;
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            kill_d[rd_ptr_q]  = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        // A same-cycle ALU write to the same register is younger, so the load is born dead.
        if (push) begin
            dir_d[wr_ptr_q]   = ld_dir;
            data_d[wr_ptr_q]  = ld_data;
            valid_d[wr_ptr_q] = 1'b1;
            kill_d[wr_ptr_q]  = (ld_dir == 5'd0) || (alu_eff && (ld_dir == alu_dir));
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_d[i] && !kill_d[i]) busy_d = busy_d | (32'd1 << dir_d[i]);
        end
    end

    // Output select and starvation tracking
    always_comb begin
        reg_wr_d = 1'b0;
        dir_wr_d = dir_wr_q;
        di_d     = di_q;
        starve_d = starve_q;
        stall_d  = stall_q;

        if (alu_eff) begin
            reg_wr_d = 1'b1;
            dir_wr_d = alu_dir;
            di_d     = alu_data;
        end else if (pop) begin
            reg_wr_d = !kill_q[rd_ptr_q];
            dir_wr_d = dir_q[rd_ptr_q];
            di_d     = data_q[rd_ptr_q];
        end

        if (pop) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else if (alu_eff && (count_q != '0)) begin
            if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
            stall_d = (starve_d == SW'(STARVE_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                dir_q[i]  <= '0;
                data_q[i] <= '0;
            end
            kill_q   <= '0;
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            reg_wr_q <= 1'b0;
            dir_wr_q <= '0;
            di_q     <= '0;
            busy_q   <= '0;
        end else begin
            dir_q    <= dir_d;
            data_q   <= data_d;
            kill_q   <= kill_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            reg_wr_q <= reg_wr_d;
            dir_wr_q <= dir_wr_d;
            di_q     <= di_d;
            busy_q   <= busy_d;
        end
    end

    assign REG_WR    = reg_wr_q;
    assign DIR_WR    = dir_wr_q;
    assign DI        = di_q;
    assign busy_mask = busy_q;
    assign stall_req = stall_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = reg_wr_d;
    assign byp_dir   = dir_wr_d;
    assign byp_data  = di_d;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_dir;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dir;
    logic [31:0] ld_data;
    logic        REG_WR;
    logic [4:0]  DIR_WR;
    logic [31:0] DI;
    logic [31:0] busy_mask;
    logic        stall_req;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_dir;
    logic [31:0] byp_data;
`endif

    int checks;
    int failures;

    wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_dir   (alu_dir),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_dir    (ld_dir),
        .ld_data   (ld_data),
        .REG_WR    (REG_WR),
        .DIR_WR    (DIR_WR),
        .DI        (DI),
        .busy_mask (busy_mask),
`ifdef WB_BYPASS_EN
        .byp_valid (byp_valid),
        .byp_dir   (byp_dir),
        .byp_data  (byp_data),
`endif
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_dir   = 5'd0;
        alu_data  = 32'd0;
        ld_valid  = 1'b0;
        ld_dir    = 5'd0;
        ld_data   = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL rst_reg_wr got=%0b exp=0", REG_WR); end
        checks++; if (DIR_WR !== 5'd0) begin failures++; $display("FAIL rst_dir_wr got=%0d exp=0", DIR_WR); end
        checks++; if (DI !== 32'd0) begin failures++; $display("FAIL rst_di got=%h exp=0", DI); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%0b exp=1", ld_ready); end
        checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy_mask); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall_req); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_write();
        alu_valid = 1'b1; alu_dir = 5'd5; alu_data = 32'h1234_5678;
        step();
        checks++; if (REG_WR !== 1'b1) begin failures++; $display("FAIL alu_wr got=%0b exp=1", REG_WR); end
        checks++; if (DIR_WR !== 5'd5) begin failures++; $display("FAIL alu_dir got=%0d exp=5", DIR_WR); end
        checks++; if (DI !== 32'h1234_5678) begin failures++; $display("FAIL alu_di got=%h exp=12345678", DI); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL alu_wr_off got=%0b exp=0", REG_WR); end
        checks++; if (DIR_WR !== 5'd5) begin failures++; $display("FAIL alu_dir_hold got=%0d exp=5", DIR_WR); end
    endtask

    task automatic test_load_order();
        ld_valid = 1'b1; ld_dir = 5'd3; ld_data = 32'hA;
        step();
        checks++; if (busy_mask !== 32'h08) begin failures++; $display("FAIL ld_busy1 got=%h exp=8", busy_mask); end
        checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL ld_nowr got=%0b exp=0", REG_WR); end
        ld_dir = 5'd4; ld_data = 32'hB;
        step();
        checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd3 || DI !== 32'hA) begin failures++;
            $display("FAIL ld_first got=%0b/%0d/%h exp=1/3/a", REG_WR, DIR_WR, DI); end
        checks++; if (busy_mask !== 32'h10) begin failures++; $display("FAIL ld_busy2 got=%h exp=10", busy_mask); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd4 || DI !== 32'hB) begin failures++;
            $display("FAIL ld_second got=%0b/%0d/%h exp=1/4/b", REG_WR, DIR_WR, DI); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL ld_busy0 got=%h exp=0", busy_mask); end
        step();
        checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL ld_drained got=%0b exp=0", REG_WR); end
    endtask

    task automatic test_starvation();
        // ALU hammers r9 while loads to r10..r13 fill the queue; r14 must be refused.
        for (int k = 1; k <= 9; k++) begin
            alu_valid = 1'b1; alu_dir = 5'd9; alu_data = 32'h900 + 32'(k);
            ld_valid  = 1'b1;
            ld_dir    = (k <= 4) ? 5'(9 + k) : 5'd14;
            ld_data   = (k <= 4) ? 32'h100 + 32'(k) : 32'hEEEE;
            step();
            checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd9) begin failures++;
                $display("FAIL starve_alu k=%0d got=%0b/%0d exp=1/9", k, REG_WR, DIR_WR); end
            if (k == 4) begin
                checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", ld_ready); end
            end
            if (k == 8) begin
                checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_early got=%0b exp=0", stall_req); end
            end
        end
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL stall_set got=%0b exp=1", stall_req); end
        checks++; if (busy_mask !== 32'h0000_3C00) begin failures++; $display("FAIL full_busy got=%h exp=3c00", busy_mask); end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'(9 + k) || DI !== 32'h100 + 32'(k)) begin failures++;
                $display("FAIL drain k=%0d got=%0b/%0d/%h exp=1/%0d/%h", k, REG_WR, DIR_WR, DI, 9 + k, 32'h100 + 32'(k)); end
            if (k == 1) begin
                checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_clear got=%0b exp=0", stall_req); end
                checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL ready_back got=%0b exp=1", ld_ready); end
            end
        end
        step();
        checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL drain_end got=%0b exp=0", REG_WR); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL drain_busy got=%h exp=0", busy_mask); end
    endtask

    task automatic test_cancel();
        ld_valid = 1'b1; ld_dir = 5'd7; ld_data = 32'h77;
        step();
        checks++; if (busy_mask !== 32'h80) begin failures++; $display("FAIL cancel_busy got=%h exp=80", busy_mask); end
        idle_inputs();
        alu_valid = 1'b1; alu_dir = 5'd7; alu_data = 32'hAA;
        step();
        checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd7 || DI !== 32'hAA) begin failures++;
            $display("FAIL cancel_alu got=%0b/%0d/%h exp=1/7/aa", REG_WR, DIR_WR, DI); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL cancel_busy0 got=%h exp=0", busy_mask); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b0 || DI !== 32'h77) begin failures++;
            $display("FAIL cancel_pop got=%0b/%h exp=0/77", REG_WR, DI); end
        // Same-cycle push and ALU write to r8
        alu_valid = 1'b1; alu_dir = 5'd8; alu_data = 32'h88;
        ld_valid  = 1'b1; ld_dir  = 5'd8; ld_data  = 32'h808;
        step();
        checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd8) begin failures++;
            $display("FAIL same_alu got=%0b/%0d exp=1/8", REG_WR, DIR_WR); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL same_busy got=%h exp=0", busy_mask); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b0 || DI !== 32'h808) begin failures++;
            $display("FAIL same_pop got=%0b/%h exp=0/808", REG_WR, DI); end
    endtask

    task automatic test_reg_zero();
        alu_valid = 1'b1; alu_dir = 5'd0; alu_data = 32'hDEAD;
        ld_valid  = 1'b1; ld_dir  = 5'd0; ld_data  = 32'h55;
        step();
        checks++; if (REG_WR !== 1'b0 || DIR_WR !== 5'd8 || DI !== 32'h808) begin failures++;
            $display("FAIL zero_alu got=%0b/%0d/%h exp=0/8/808", REG_WR, DIR_WR, DI); end
        checks++; if (busy_mask !== 32'h0) begin failures++; $display("FAIL zero_busy got=%h exp=0", busy_mask); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b0 || DIR_WR !== 5'd0 || DI !== 32'h55) begin failures++;
            $display("FAIL zero_pop got=%0b/%0d/%h exp=0/0/55", REG_WR, DIR_WR, DI); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", ld_ready); end
    endtask

    task automatic test_reset_mid_drain();
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1; alu_dir = 5'd20; alu_data = 32'h2000;
            ld_valid  = 1'b1; ld_dir  = 5'(20 + k); ld_data = 32'h300 + 32'(k);
            step();
        end
        checks++; if (busy_mask !== 32'h00E0_0000) begin failures++; $display("FAIL mid_busy got=%h exp=e00000", busy_mask); end
        idle_inputs();
        step();
        checks++; if (REG_WR !== 1'b1 || DIR_WR !== 5'd21) begin failures++;
            $display("FAIL mid_pop got=%0b/%0d exp=1/21", REG_WR, DIR_WR); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (REG_WR !== 1'b0 || DIR_WR !== 5'd0 || DI !== 32'd0) begin failures++;
            $display("FAIL mid_rst_out got=%0b/%0d/%h exp=0/0/0", REG_WR, DIR_WR, DI); end
        checks++; if (busy_mask !== 32'h0 || ld_ready !== 1'b1 || stall_req !== 1'b0) begin failures++;
            $display("FAIL mid_rst_state got=%h/%0b/%0b exp=0/1/0", busy_mask, ld_ready, stall_req); end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (REG_WR !== 1'b0) begin failures++; $display("FAIL post_rst k=%0d got=%0b exp=0", k, REG_WR); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_alu_write();
        test_load_order();
        test_starvation();
        test_cancel();
        test_reg_zero();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
